seq_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU. Provides ADD/SUB/AND/ORR/EOR with ARM-style NZCV flags at configurable width, plus iterative unsigned multiply and, optionally, unsigned divide. Result and flags are registered. Sits between the multicycle datapath's operand registers and its result/flag write-back, with a valid/ready pair on each side.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/seq_alu_if.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag bit positions.
// SEQ_ALU_DIV_EN selects whether opcode 110 runs the iterative divider.
package alu_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned FLG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_ORR  = 3'b011;
    localparam logic [OP_W-1:0] OP_EOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_UDIV = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that run through the multi-cycle shift datapath.
    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_UDIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the datapath (master) and the ALU (slave).
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
) ();
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      op;
    logic [WIDTH-1:0]     src_a;
    logic [WIDTH-1:0]     src_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [FLG_W-1:0]     flags;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiplier / restoring divider, one bit per enabled cycle.
// Divider datapath exists only when SEQ_ALU_DIV_EN is defined.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             en_i,
    input  logic             op_is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] step_res_c_o
);

    // acc: product accumulator / partial remainder
    // opnd: shifting multiplicand / divisor
    // shf: shifting multiplier / dividend-in, quotient-out
    logic [WIDTH-1:0] acc_q,  acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] shf_q,  shf_d;

`ifdef SEQ_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
`else
    logic             unused_div;
    assign unused_div = op_is_div_i;
`endif

    always_comb begin
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        shf_d        = shf_q;
        step_res_c_o = acc_q;
`ifdef SEQ_ALU_DIV_EN
        div_d   = div_q;
        trial_c = {acc_q, shf_q[WIDTH-1]};
        diff_c  = trial_c - {1'b0, opnd_q};
        ge_c    = ~diff_c[WIDTH];
`endif
        if (start_i) begin
            acc_d = '0;
`ifdef SEQ_ALU_DIV_EN
            div_d  = op_is_div_i;
            opnd_d = op_is_div_i ? b_i : a_i;
            shf_d  = op_is_div_i ? a_i : b_i;
`else
            opnd_d = a_i;
            shf_d  = b_i;
`endif
        end else if (en_i) begin
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
                // Keep the trial remainder only when the divisor fits.
                acc_d        = ge_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
                shf_d        = {shf_q[WIDTH-2:0], ge_c};
                step_res_c_o = (opnd_q == '0) ? '0 : shf_d;
            end else
`endif
            begin
                acc_d        = shf_q[0] ? (acc_q + opnd_q) : acc_q;
                opnd_d       = {opnd_q[WIDTH-2:0], 1'b0};
                shf_d        = {1'b0, shf_q[WIDTH-1:1]};
                step_res_c_o = acc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            shf_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            shf_q  <= shf_d;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops, WIDTH-cycle multiply and optional divide.
// Define SEQ_ALU_DIV_EN to enable UDIV; otherwise op 110 is treated as reserved.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    seq_alu_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_c;
    logic               start_c;
    logic [WIDTH-1:0]   step_res_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [WIDTH-1:0]   sc_res_c;
    logic               sc_c_c;
    logic               sc_v_c;

    function automatic logic [FLG_W-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                  input logic c, input logic v);
        logic [FLG_W-1:0] f;
        f        = '0;
        f[FLG_N] = r[WIDTH-1];
        f[FLG_Z] = (r == '0);
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

    assign accept_c = in_ready_q && bus.in_valid;
    assign start_c  = accept_c && is_iter_op(bus.op);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_c),
        .en_i         (state_q == ST_ITER),
        .op_is_div_i  (bus.op == OP_UDIV),
        .a_i          (bus.src_a),
        .b_i          (bus.src_b),
        .step_res_c_o (step_res_c)
    );

    // Single-cycle ops evaluated straight from the presented operands.
    always_comb begin
        sum_c    = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        diff_c   = {1'b0, bus.src_a} - {1'b0, bus.src_b};
        sc_res_c = '0;
        sc_c_c   = 1'b0;
        sc_v_c   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res_c = sum_c[WIDTH-1:0];
                sc_c_c   = sum_c[WIDTH];
                sc_v_c   = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                           (sum_c[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_c = diff_c[WIDTH-1:0];
                sc_c_c   = ~diff_c[WIDTH];
                sc_v_c   = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                           (diff_c[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            OP_AND:  sc_res_c = bus.src_a & bus.src_b;
            OP_ORR:  sc_res_c = bus.src_a | bus.src_b;
            OP_EOR:  sc_res_c = bus.src_a ^ bus.src_b;
            OP_MUL, OP_UDIV, OP_RSVD: sc_res_c = '0;
            default: sc_res_c = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_iter_op(bus.op)) begin
                        state_d = ST_ITER;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_res_c;
                        flags_d  = mk_flags(sc_res_c, sc_c_c, sc_v_c);
                    end
                end
            end
            ST_ITER: begin
                // Final step lands in result at the edge where the counter reads 0.
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    result_d = step_res_c;
                    flags_d  = mk_flags(step_res_c, 1'b0, 1'b0);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int          LIM   = WIDTH + 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic [3:0] f, output int lat);
        longint sa, sb, s;
        logic [63:0] wide;
        logic c, v;
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0; v = 1'b0; lat = 1; r = '0;
        case (op)
            3'd0: begin
                wide = 64'(a) + 64'(b); r = wide[31:0]; c = wide[32];
                s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b; c = (a >= b);
                s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                wide = 64'(a) * 64'(b); r = wide[31:0]; lat = WIDTH + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            3'd6: begin
                r = (b == 0) ? 32'd0 : a / b; lat = WIDTH + 1;
            end
`endif
            default: r = '0;
        endcase
        f = {r[31], (r == 0), c, v};
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke);
        logic [31:0] er;
        logic [3:0]  ef;
        int          elat, lat;
        model(op, a, b, er, ef, elat);
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < LIM) begin
            if (poke) begin
                bus.in_valid = 1'b1; bus.op = 3'($urandom);
                bus.src_a = $urandom; bus.src_b = $urandom;
                chk("busy_in_ready", bus.in_ready, 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(elat));
        chk("result", bus.result, er);
        chk("flags", bus.flags, ef);
        chk("done_in_ready", bus.in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_result", bus.result, er);
            chk("hold_flags", bus.flags, ef);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("xfer_out_valid", bus.out_valid, 0);
        chk("xfer_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", bus.flags, 0);

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 0);
        run_op(OP_SUB, 32'd5, 32'd5, 0, 0);
        run_op(OP_SUB, 32'd3, 32'd5, 0, 0);
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op(OP_SUB, 32'h8000_0000, 32'h1, 0, 0);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0);
        run_op(OP_ORR, 32'h0, 32'h0, 0, 0);
        run_op(OP_EOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0);
        run_op(OP_MUL, 32'h0001_0001, 32'h0001_0001, 5, 0);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        run_op(OP_UDIV, 32'd100, 32'd7, 0, 0);
        run_op(OP_UDIV, 32'd9, 32'd0, 0, 0);
        run_op(OP_RSVD, 32'h1234, 32'h5678, 1, 0);

        // Reset in the middle of a multiply must leave no trace.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.src_a = 32'd12345; bus.src_b = 32'd678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_flags", bus.flags, 0);
        stale = 0;
        repeat (WIDTH + 5) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 6 == 0) ? 32'd0 : (i % 6 == 1) ? ra : $urandom;
            if (i % 4 == 2) rb = rb >> $urandom_range(0, 31);
            run_op(rop, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
